// File: rtl/kmer_extractor.sv
// Rolling 2-bit k-mer packer feeding the hash stage.
// Emits forward or canonical keys with read offset and last flag.
module kmer_extractor #(
  parameter int K         = 21,
  parameter int KEY_W     = 2 * K,
  parameter int POS_W     = 32,
  parameter bit CANONICAL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_CHAR,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [KEY_W-1:0] KEY,
  output logic [POS_W-1:0] KEY_POS,
  output logic             KEY_LAST,
  output logic [15:0]      SKIP_CNT
);

  localparam int FW = $clog2(K + 1);

  typedef enum logic {
    FILL,
    STREAM
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [KEY_W-1:0] fwd_q, fwd_d;
  logic [KEY_W-1:0] rc_q, rc_d;
  logic             ov_q, ov_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [POS_W-1:0] kpos_q, kpos_d;
  logic             klast_q, klast_d;
  logic [15:0]      skip_q, skip_d;

  logic [1:0]       code;
  logic             is_base;
  logic [7:0]       ch_lc;
  logic             accept;
  logic             full_n;
  logic [KEY_W-1:0] fwd_n;
  logic [KEY_W-1:0] rc_n;
  logic [KEY_W-1:0] canon;

  // Forcing bit 5 folds upper and lower case together.
  assign ch_lc = IN_CHAR | 8'h20;

  always_comb begin
    code    = 2'b00;
    is_base = 1'b0;
    unique case (1'b1)
      (ch_lc == 8'h61): begin
        code    = 2'b00;
        is_base = 1'b1;
      end
      (ch_lc == 8'h63): begin
        code    = 2'b01;
        is_base = 1'b1;
      end
      (ch_lc == 8'h67): begin
        code    = 2'b10;
        is_base = 1'b1;
      end
      (ch_lc == 8'h74): begin
        code    = 2'b11;
        is_base = 1'b1;
      end
      default: begin
        code    = 2'b00;
        is_base = 1'b0;
      end
    endcase
  end

  assign IN_READY = !ov_q | OUT_READY;
  assign accept   = IN_VALID & IN_READY;

  assign fwd_n = {fwd_q[KEY_W-3:0], code};
  assign rc_n  = {~code, rc_q[KEY_W-1:2]};

  // Window is full after this base if already streaming or this is base K.
  assign full_n = (state_q == STREAM) | (fill_q == FW'(K - 1));

  assign canon = (CANONICAL && (rc_n < fwd_n)) ? rc_n : fwd_n;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    pos_d   = pos_q;
    fwd_d   = fwd_q;
    rc_d    = rc_q;
    ov_d    = ov_q;
    key_d   = key_q;
    kpos_d  = kpos_q;
    klast_d = klast_q;
    skip_d  = skip_q;

    if (OUT_READY) begin
      ov_d = 1'b0;
    end

    if (accept) begin
      pos_d = pos_q + 1'b1;
      if (is_base) begin
        fwd_d = fwd_n;
        rc_d  = rc_n;
        if (full_n) begin
          fill_d  = FW'(K);
          state_d = STREAM;
          ov_d    = 1'b1;
          key_d   = canon;
          kpos_d  = pos_q - POS_W'(K - 1);
          klast_d = IN_LAST;
        end else begin
          fill_d  = fill_q + 1'b1;
          state_d = FILL;
        end
      end else begin
        fill_d  = '0;
        state_d = FILL;
        if (skip_q != 16'hFFFF) begin
          skip_d = skip_q + 16'd1;
        end
      end
      if (IN_LAST) begin
        fill_d  = '0;
        pos_d   = '0;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      fill_q  <= '0;
      pos_q   <= '0;
      fwd_q   <= '0;
      rc_q    <= '0;
      ov_q    <= 1'b0;
      key_q   <= '0;
      kpos_q  <= '0;
      klast_q <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pos_q   <= pos_d;
      fwd_q   <= fwd_d;
      rc_q    <= rc_d;
      ov_q    <= ov_d;
      key_q   <= key_d;
      kpos_q  <= kpos_d;
      klast_q <= klast_d;
      skip_q  <= skip_d;
    end
  end

  assign OUT_VALID = ov_q;
  assign KEY       = key_q;
  assign KEY_POS   = kpos_q;
  assign KEY_LAST  = klast_q;
  assign SKIP_CNT  = skip_q;

endmodule
